// File: rtl/mips_cpu_muldiv_if.sv
// Command/result bundle between the execute stage and the mul/div unit.
// master: execute stage (drives start/op/a/b, reads busy/done/hi/lo).
// slave : mips_cpu_muldiv (the reverse directions).
interface mips_cpu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// Ports: clk, rst (sync, active-high), bus (slave: start/op/a/b in,
// busy/done/hi/lo out). Define MIPS_CPU_MULDIV_FAST_MUL_EN for a
// single-cycle multiplier; otherwise MULT/MULTU iterate like division.
module mips_cpu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    mips_cpu_muldiv_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;

    logic               w_accept;
    logic               w_md;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    logic [WIDTH:0]     w_top;
    logic [WIDTH+1:0]   w_diff;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_mul_nxt;

    logic               w_busy;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_accept = bus.start && (r_state == S_IDLE);
    assign w_md     = (bus.op <= OP_DIVU);
    assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_a_neg  = w_signed && bus.a[WIDTH-1];
    assign w_b_neg  = w_signed && bus.b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~bus.a + 1'b1) : bus.a;
    assign w_b_mag  = w_b_neg ? (~bus.b + 1'b1) : bus.b;

`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
`endif

    // Restoring divide: r_acc = {rem, quot}. The shifted remainder
    // needs WIDTH+1 bits because the pre-shift remainder is < divisor.
    assign w_top     = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = {1'b0, w_top} - {2'b00, r_opb};
    assign w_div_nxt = w_diff[WIDTH+1]
                     ? {w_top[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // Shift-add multiply: r_acc = {partial, multiplier}, shifting right.
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && w_md) begin
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
                    w_next = bus.op[1] ? S_CALC : S_FIX;
`else
                    w_next = S_CALC;
`endif
                end
            end
            S_CALC:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != S_IDLE);
        w_prod   = r_neg_q ? (~r_acc + 1'b1) : r_acc;
        w_quot   = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
        w_rem    = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                           : r_acc[2*WIDTH-1:WIDTH];
        w_fix_hi = r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = r_is_div ? w_quot : w_prod[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept && w_md) begin
                        r_cnt    <= CNT_W'(WIDTH - 1);
                        r_is_div <= bus.op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        // remainder follows the dividend's sign
                        r_neg_r  <= w_a_neg & bus.op[1];
                        r_opb    <= bus.op[1] ? w_b_mag : w_a_mag;
                        if (bus.op[1]) begin
                            r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                        end else begin
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
                            r_acc <= w_fast_prod;
`else
                            r_acc <= {{WIDTH{1'b0}}, w_b_mag};
`endif
                        end
                    end else if (w_accept && bus.op == OP_MTHI) begin
                        r_hi <= bus.a;
                    end else if (w_accept && bus.op == OP_MTLO) begin
                        r_lo <= bus.a;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                end
                S_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed corner cases plus
// random commands checked against an arithmetic HI/LO reference model.
module tb_mips_cpu_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mips_cpu_muldiv_if #(.WIDTH(32)) bus ();

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int lat(input logic [2:0] op);
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
        if (op <= 3'd1) return 1;
`endif
        return 33;
    endfunction

    // Expected HI/LO after the command, from plain arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] eh,
                         output logic [31:0] el);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = m_hi;
        el = m_lo;
        case (op)
            3'd0: begin
                p  = 64'(sa * sb);
                eh = p[63:32];
                el = p[31:0];
            end
            3'd1: begin
                p  = {32'd0, a} * {32'd0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    el = a[31] ? 32'h1 : 32'hFFFF_FFFF;
                    eh = a;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
            3'd3: begin
                if (b == 0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        logic [31:0] eh, el;
        int k;
        model(op, a, b, eh, el);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        if (op <= 3'd3) begin
            chk({tag, "/busy_start"}, {31'd0, bus.busy}, 32'd1);
            chk({tag, "/done_start"}, {31'd0, bus.done}, 32'd0);
            k = 0;
            while (!bus.done && k < 200) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk({tag, "/latency"}, k, lat(op));
            chk({tag, "/busy_done"}, {31'd0, bus.busy}, 32'd0);
        end else begin
            chk({tag, "/done"}, {31'd0, bus.done}, 32'd0);
            chk({tag, "/busy"}, {31'd0, bus.busy}, 32'd0);
        end
        chk({tag, "/hi"}, bus.hi, eh);
        chk({tag, "/lo"}, bus.lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] edges [5];
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 300));
        return $urandom;
    endfunction

    initial begin
        logic [31:0] eh, el;
        int k, nd;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset/busy", {31'd0, bus.busy}, 32'd0);
        chk("reset/done", {31'd0, bus.done}, 32'd0);
        chk("reset/hi", bus.hi, 32'd0);
        chk("reset/lo", bus.lo, 32'd0);

        do_op(3'd0, 32'hFFFF_FFFE, 32'h3, "mult_neg2x3");
        @(posedge clk);
        #1;
        chk("mult/done_pulse", {31'd0, bus.done}, 32'd0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        do_op(3'd2, 32'hFFFF_FFF9, 32'h2, "div_neg7");
        do_op(3'd3, 32'hFFFF_FFF9, 32'h2, "divu_7");
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(3'd3, 32'h5, 32'h0, "divu_by0");
        do_op(3'd2, 32'hFFFF_FFF9, 32'h0, "div_neg_by0");
        do_op(3'd4, 32'h1234_5678, 32'h0, "mthi");
        do_op(3'd5, 32'hCAFE_F00D, 32'h0, "mtlo");
        do_op(3'd6, 32'hDEAD_BEEF, 32'h1, "op6");
        do_op(3'd7, 32'hDEAD_BEEF, 32'h1, "op7");

        // MTLO issued while a divide is in flight must be dropped
        model(3'd2, 32'd1000, 32'd7, eh, el);
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.a     = 32'd1000;
        bus.b     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.a     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        k = 4;
        while (!bus.done && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("mtlo_busy/latency", k, 33);
        chk("mtlo_busy/hi", bus.hi, eh);
        chk("mtlo_busy/lo", bus.lo, el);
        m_hi = eh;
        m_lo = el;

        // reset in the middle of a divide discards it
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.a     = 32'd12345;
        bus.b     = 32'd11;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst/busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst/done", {31'd0, bus.done}, 32'd0);
        chk("midrst/hi", bus.hi, 32'd0);
        chk("midrst/lo", bus.lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        chk("midrst/no_done", nd, 0);
        do_op(3'd3, 32'd100, 32'd7, "divu_100_7");

        for (int i = 0; i < 30; i++) begin
            do_op(3'($urandom_range(0, 7)), pick(), pick(), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Parametrised multi-cycle multiply/divide unit that owns the architectural HI/LO registers for the MIPS datapath. It takes MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the execute stage through a start/busy/done handshake and runs an iterative shift-subtract divider. Multiplication is either a single-cycle multiplier or an iterative shift-add, selected at compile time. The execute-stage ALU keeps single-cycle logic/arithmetic/shift/compare operations; HI/LO traffic routes here.

## Interface
- WIDTH, 32, operand width and HI/LO register width; any value ≥ 4
- CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  command valid; accepted only in a cycle where busy=0
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6–7 ignored
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data)
- b  input  WIDTH  rt operand (divisor / multiplier)
- busy  output  1  high while a mul/div is in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse: new HI/LO first visible this cycle
- hi  output  WIDTH  HI register (registered)
- lo  output  WIDTH  LO register (registered)

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start=1 with op 0–3 latches operands, op, and signedness. Signed ops store operand magnitudes plus result-sign flags. Transition to CALC with counter=WIDTH-1. With the fast multiplier, MULT/MULTU go directly to FIX.
- CALC: one iteration per cycle.
  - Division is restoring: shift the {rem,quot} pair left by one, trial-subtract the divisor, set the quotient bit when there is no borrow.
  - Multiplication is shift-add over a 2·WIDTH accumulator.
  - The counter decrements each cycle. At counter=0 the next state is FIX.
- FIX: apply sign correction, write hi/lo, assert done (registered), return to IDLE.
  - MULT/MULTU: hi = product[2W-1:W], lo = product[W-1:0]. Signed product negates when the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder. The quotient is negated when the signs differ. The remainder takes the sign of the dividend.
- MTHI/MTLO in IDLE: write hi (or lo) with a at that edge. The other register is unchanged. There is no busy and no done pulse.
- start while busy=1: ignored entirely, including MTHI/MTLO. The pipeline must stall on busy.
- op 6–7: ignored, no state change.
- Divide by zero: no trap. The natural algorithm result is returned: quotient = all ones (before sign fix), remainder = |dividend|, then the normal sign rules apply.
- Signed overflow (most-negative ÷ −1): lo = most-negative value, hi = 0.
- hi/lo hold their previous values throughout CALC/FIX until the FIX edge.

## Timing
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. This applies from any state; an in-flight operation is discarded with no HI/LO write.
- Start accepted at edge E0. Iterative op: CALC occupies the cycles after E0..E(WIDTH), FIX occupies the cycle after E(WIDTH). hi/lo update and done=1 at edge E(WIDTH+1). Latency is WIDTH+1 cycles (33 for WIDTH=32).
- Fast multiply: FIX in the cycle after E0; hi/lo and done at E1. Latency is 1 cycle.
- busy falls in the same cycle done rises. A new start is accepted in that done cycle.
- MTHI/MTLO: hi/lo visible the cycle after the accepting edge.
- done is never high for two consecutive cycles unless back-to-back fast multiplies are issued.

## Configuration
- MIPS_CPU_MULDIV_FAST_MUL_EN defined: MULT/MULTU use a combinational WIDTH×WIDTH multiplier captured in the operand register. Latency is 1 cycle. Division is unchanged.
- Not defined: MULT/MULTU use the iterative shift-add with the same WIDTH+1 latency as division. No hardware multiplier is inferred.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=0x00000003 -> after 33 cycles (or 1 with FAST_MUL_EN), hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one-cycle pulse, busy low the same cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
- MTHI a=0x12345678 while idle -> hi=0x12345678 next cycle, lo unchanged, no done. MTLO issued while busy -> ignored, and the final lo comes from the running op.
- Start DIV, assert rst at cycle 10 -> next cycle busy=0, hi=lo=0, no done. A fresh DIVU 100/7 then yields lo=14, hi=2 at WIDTH+1 cycles.
